// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters.
// One operation in flight: IDLE (grant/accept) -> EXEC (ALU settles) -> RESP (return result).
module alu_arbiter #(
   parameter int unsigned WIDTH         = 32,
   parameter logic [15:0] OP_COUNT_INIT = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid0,
   input  logic             req_valid1,
   output logic             req_ready0,
   output logic             req_ready1,
   input  logic [2:0]       req_funct3_0,
   input  logic [2:0]       req_funct3_1,
   input  logic [WIDTH-1:0] req_a0,
   input  logic [WIDTH-1:0] req_a1,
   input  logic [WIDTH-1:0] req_b0,
   input  logic [WIDTH-1:0] req_b1,
   output logic             rsp_valid0,
   output logic             rsp_valid1,
   input  logic             rsp_ready0,
   input  logic             rsp_ready1,
   output logic [WIDTH-1:0] rsp_data,
   output logic [WIDTH-1:0] aluin1,
   output logic [WIDTH-1:0] aluin2,
   output logic [2:0]       funct3,
   input  logic [WIDTH-1:0] aluout,
   output logic             busy,
   output logic [15:0]      op_count
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_e;

   state_e           state_q;
   logic             last_q;
   logic             owner_q;
   logic [WIDTH-1:0] aluin1_q;
   logic [WIDTH-1:0] aluin2_q;
   logic [2:0]       funct3_q;
   logic [WIDTH-1:0] rsp_data_q;
   logic             rsp_valid0_q;
   logic             rsp_valid1_q;
   logic [15:0]      op_count_q;

   logic             any_req;
   logic             gnt_d;
   logic             rsp_done;

   // On contention the port that was not served last wins; a lone requester always wins.
   assign any_req  = req_valid0 | req_valid1;
   assign gnt_d    = (req_valid0 & req_valid1) ? ~last_q : req_valid1;
   assign rsp_done = owner_q ? rsp_ready1 : rsp_ready0;

   assign req_ready0 = (state_q == IDLE) & req_valid0 & ~gnt_d;
   assign req_ready1 = (state_q == IDLE) & req_valid1 & gnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_q       <= 1'b1;
         owner_q      <= 1'b0;
         aluin1_q     <= '0;
         aluin2_q     <= '0;
         funct3_q     <= '0;
         rsp_data_q   <= '0;
         rsp_valid0_q <= 1'b0;
         rsp_valid1_q <= 1'b0;
         op_count_q   <= OP_COUNT_INIT;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  aluin1_q <= gnt_d ? req_a1 : req_a0;
                  aluin2_q <= gnt_d ? req_b1 : req_b0;
                  funct3_q <= gnt_d ? req_funct3_1 : req_funct3_0;
                  owner_q  <= gnt_d;
                  last_q   <= gnt_d;
                  state_q  <= EXEC;
               end
            end
            EXEC: begin
               rsp_data_q   <= aluout;
               rsp_valid0_q <= ~owner_q;
               rsp_valid1_q <= owner_q;
               state_q      <= RESP;
            end
            RESP: begin
               if (rsp_done) begin
                  rsp_valid0_q <= 1'b0;
                  rsp_valid1_q <= 1'b0;
                  if (op_count_q != 16'hFFFF) begin
                     op_count_q <= op_count_q + 16'd1;
                  end
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign aluin1     = aluin1_q;
   assign aluin2     = aluin2_q;
   assign funct3     = funct3_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_valid0 = rsp_valid0_q;
   assign rsp_valid1 = rsp_valid1_q;
   assign busy       = (state_q != IDLE);
   assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; a second instance preloaded near saturation shares the stimulus.
module tb_alu_arbiter;

   localparam int unsigned W = 32;

   logic         clk;
   logic         rst_n;
   logic         req_valid0, req_valid1;
   logic [2:0]   req_funct3_0, req_funct3_1;
   logic [W-1:0] req_a0, req_a1, req_b0, req_b1;
   logic         rsp_ready0, rsp_ready1;

   logic         req_ready0, req_ready1, rsp_valid0, rsp_valid1, busy;
   logic [W-1:0] rsp_data, aluin1, aluin2, aluout;
   logic [2:0]   funct3;
   logic [15:0]  op_count;

   logic         s_req_ready0, s_req_ready1, s_rsp_valid0, s_rsp_valid1, s_busy;
   logic [W-1:0] s_rsp_data, s_aluin1, s_aluin2, s_aluout;
   logic [2:0]   s_funct3;
   logic [15:0]  s_op_count;

   int checks;
   int failures;

   function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] f);
      case (f)
         3'b000:  alu_f = a + b;
         3'b100:  alu_f = a ^ b;
         3'b110:  alu_f = a | b;
         3'b111:  alu_f = a & b;
         default: alu_f = a - b;
      endcase
   endfunction

   assign aluout   = alu_f(aluin1, aluin2, funct3);
   assign s_aluout = alu_f(s_aluin1, s_aluin2, s_funct3);

   alu_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid0(req_valid0), .req_valid1(req_valid1),
      .req_ready0(req_ready0), .req_ready1(req_ready1),
      .req_funct3_0(req_funct3_0), .req_funct3_1(req_funct3_1),
      .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
      .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
      .rsp_ready0(rsp_ready0), .rsp_ready1(rsp_ready1),
      .rsp_data(rsp_data), .aluin1(aluin1), .aluin2(aluin2), .funct3(funct3),
      .aluout(aluout), .busy(busy), .op_count(op_count)
   );

   alu_arbiter #(.WIDTH(W), .OP_COUNT_INIT(16'hFFFE)) dut_sat (
      .clk(clk), .rst_n(rst_n),
      .req_valid0(req_valid0), .req_valid1(req_valid1),
      .req_ready0(s_req_ready0), .req_ready1(s_req_ready1),
      .req_funct3_0(req_funct3_0), .req_funct3_1(req_funct3_1),
      .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
      .rsp_valid0(s_rsp_valid0), .rsp_valid1(s_rsp_valid1),
      .rsp_ready0(rsp_ready0), .rsp_ready1(rsp_ready1),
      .rsp_data(s_rsp_data), .aluin1(s_aluin1), .aluin2(s_aluin2), .funct3(s_funct3),
      .aluout(s_aluout), .busy(s_busy), .op_count(s_op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance to a point 2 time units past the next rising edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      rst_n        = 1'b1;
      req_valid0   = 1'b0;
      req_valid1   = 1'b0;
      req_funct3_0 = '0;
      req_funct3_1 = '0;
      req_a0       = '0;
      req_a1       = '0;
      req_b0       = '0;
      req_b1       = '0;
      rsp_ready0   = 1'b0;
      rsp_ready1   = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_aluin1", aluin1, 0);
      check("rst_op_count", op_count, 0);
      check("rst_rsp_valid0", rsp_valid0, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Single request on port 0: 7 + 10.
      req_valid0 = 1'b1; req_a0 = 7; req_b0 = 10; req_funct3_0 = 3'b000;
      #1;
      check("single_ready0", req_ready0, 1);
      check("single_ready1", req_ready1, 0);
      tick();
      req_valid0 = 1'b0;
      check("single_aluin1", aluin1, 7);
      check("single_aluin2", aluin2, 10);
      check("single_exec_busy", busy, 1);
      check("single_exec_valid0", rsp_valid0, 0);
      tick();
      check("single_rsp_valid0", rsp_valid0, 1);
      check("single_rsp_data", rsp_data, 17);
      check("single_rsp_valid1", rsp_valid1, 0);
      rsp_ready0 = 1'b1;
      tick();
      rsp_ready0 = 1'b0;
      check("single_done_valid0", rsp_valid0, 0);
      check("single_done_busy", busy, 0);
      check("single_op_count", op_count, 1);
      check("single_aluin_held", aluin1, 7);
      check("sat_reach", s_op_count, 16'hFFFF);

      // Simultaneous requests straight after reset: port 0 wins the first tie.
      do_reset();
      check("sim_rst_count", op_count, 0);
      req_valid0 = 1'b1; req_a0 = 7; req_b0 = 10; req_funct3_0 = 3'b000;
      req_valid1 = 1'b1; req_a1 = 3; req_b1 = 4;  req_funct3_1 = 3'b000;
      rsp_ready0 = 1'b1; rsp_ready1 = 1'b1;
      #1;
      check("sim_ready0", req_ready0, 1);
      check("sim_ready1", req_ready1, 0);
      tick();
      req_valid0 = 1'b0;
      check("sim_exec_ready1", req_ready1, 0);
      tick();
      check("sim_p0_valid0", rsp_valid0, 1);
      check("sim_p0_valid1", rsp_valid1, 0);
      check("sim_p0_data", rsp_data, 17);
      tick();
      check("sim_idle_ready1", req_ready1, 1);
      tick();
      req_valid1 = 1'b0;
      check("sim_p1_aluin1", aluin1, 3);
      tick();
      check("sim_p1_valid1", rsp_valid1, 1);
      check("sim_p1_valid0", rsp_valid0, 0);
      check("sim_p1_data", rsp_data, 7);
      tick();
      check("sim_op_count", op_count, 2);

      // Fairness: both held valid, responses always ready, 3-cycle spacing.
      req_valid0 = 1'b1; req_a0 = 32'hF0; req_b0 = 32'hFF; req_funct3_0 = 3'b100;
      req_valid1 = 1'b1; req_a1 = 32'hF0; req_b1 = 32'h3C; req_funct3_1 = 3'b111;
      #1;
      for (int k = 0; k < 6; k++) begin
         check($sformatf("fair%0d_ready0", k), req_ready0, (k % 2 == 0) ? 1 : 0);
         check($sformatf("fair%0d_ready1", k), req_ready1, (k % 2 == 1) ? 1 : 0);
         tick();
         check($sformatf("fair%0d_funct3", k), funct3, (k % 2 == 0) ? 3'b100 : 3'b111);
         tick();
         check($sformatf("fair%0d_valid0", k), rsp_valid0, (k % 2 == 0) ? 1 : 0);
         check($sformatf("fair%0d_valid1", k), rsp_valid1, (k % 2 == 1) ? 1 : 0);
         check($sformatf("fair%0d_data", k), rsp_data, (k % 2 == 0) ? 32'h0F : 32'h30);
         tick();
      end
      check("fair_op_count", op_count, 8);

      // Backpressure: port 0 holds off its response for 5 cycles while port 1 waits.
      req_a0 = 32'h12345678; req_b0 = 32'h11111111; req_funct3_0 = 3'b000;
      req_a1 = 32'h0F0F0000; req_b1 = 32'h000000F0; req_funct3_1 = 3'b110;
      rsp_ready0 = 1'b0;
      #1;
      check("bp_ready0", req_ready0, 1);
      tick();
      tick();
      for (int k = 0; k < 5; k++) begin
         check($sformatf("bp%0d_valid0", k), rsp_valid0, 1);
         check($sformatf("bp%0d_data", k), rsp_data, 32'h23456789);
         check($sformatf("bp%0d_ready1", k), req_ready1, 0);
         check($sformatf("bp%0d_valid1", k), rsp_valid1, 0);
         if (k < 4) tick();
      end
      rsp_ready0 = 1'b1;
      tick();
      req_valid0 = 1'b0;
      #1;
      check("bp_accept_ready1", req_ready1, 1);
      tick();
      req_valid1 = 1'b0;
      check("bp_p1_aluin1", aluin1, 32'h0F0F0000);
      tick();
      check("bp_p1_valid1", rsp_valid1, 1);
      check("bp_p1_data", rsp_data, 32'h0F0F00F0);
      tick();
      check("bp_op_count", op_count, 10);
      check("sat_hold", s_op_count, 16'hFFFF);

      // Reset in the middle of a response.
      req_valid0 = 1'b1; req_a0 = 5; req_b0 = 6; req_funct3_0 = 3'b000;
      rsp_ready0 = 1'b0;
      tick();
      req_valid0 = 1'b0;
      tick();
      check("mid_valid0", rsp_valid0, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid0", rsp_valid0, 0);
      check("mid_rst_aluin1", aluin1, 0);
      check("mid_rst_aluin2", aluin2, 0);
      check("mid_rst_funct3", funct3, 0);
      check("mid_rst_op_count", op_count, 0);
      check("mid_rst_rsp_data", rsp_data, 0);
      check("mid_rst_busy", busy, 0);
      tick();
      rsp_ready0 = 1'b1;
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("post_rst%0d_valid0", k), rsp_valid0, 0);
         check($sformatf("post_rst%0d_valid1", k), rsp_valid1, 0);
         check($sformatf("post_rst%0d_count", k), op_count, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the core's single combinational 32-bit `alu` between two requesters (port 0: execute stage, port 1: address/branch unit) with valid/ready handshakes. It arbitrates round-robin and registers the selected operands and `funct3` into the ALU inputs. It samples `aluout` one cycle later and returns the result to the winning requester through a response handshake. One operation is in flight at a time; a 16-bit saturating counter records completed operations.

## Interface
- `WIDTH`, 32, operand/result width; must match the ALU.
- `clk` input 1 — single clock, rising edge.
- `rst_n` input 1 — asynchronous, active-low reset.
- `req_valid0`, `req_valid1` input 1 — requester i presents an operation.
- `req_ready0`, `req_ready1` output 1 — operation accepted this cycle when valid&&ready.
- `req_funct3_0`, `req_funct3_1` input 3 — ALU function select.
- `req_a0`, `req_a1` input WIDTH — first operand.
- `req_b0`, `req_b1` input WIDTH — second operand.
- `rsp_valid0`, `rsp_valid1` output 1 — result available for requester i.
- `rsp_ready0`, `rsp_ready1` input 1 — requester i takes the result.
- `rsp_data` output WIDTH — registered result, shared by both responders.
- `aluin1`, `aluin2` output WIDTH — registered operands to the ALU.
- `funct3` output 3 — registered function select to the ALU.
- `aluout` input WIDTH — combinational ALU result.
- `busy` output 1 — high in EXEC or RESP.
- `op_count` output 16 — completed operations; saturates at 0xFFFF.

## Operation
- FSM states are IDLE, EXEC and RESP.
- **IDLE**
  - Grant is combinational from `req_valid0/1` and the `last` pointer (1 bit, the port served most recently).
  - If exactly one request is valid, that port wins. If both are valid, the port != `last` wins.
  - `req_ready_i` = (state==IDLE) && grant==i. Ready depends on the valid inputs.
  - On handshake: latch the winner's a/b/funct3 into `aluin1`/`aluin2`/`funct3`, store owner = i, set `last` = i, go to EXEC.
- **EXEC** (always exactly one cycle): `aluout` settles. At the clock edge, `rsp_data` <= `aluout`, go to RESP.
- **RESP**
  - `rsp_valid_owner` = 1 and the other `rsp_valid` = 0.
  - Hold until `rsp_ready_owner`=1. Then go to IDLE and increment `op_count` (saturating).
  - `rsp_ready` of the non-owner is ignored.
- ALU input registers are held after an operation; they change only on a new acceptance.
- Requester rule: keep valid, a, b and funct3 stable until ready. Dropping valid before ready is legal and withdraws the request.
- No requests are accepted in EXEC or RESP; `req_ready0/1` = 0 there.

## Timing
- Reset (async on `rst_n`=0) immediately sets:
  - state=IDLE, `last`=1 (port 0 wins the first tie);
  - `aluin1`=`aluin2`=0, `funct3`=000, `rsp_data`=0, `op_count`=0;
  - `rsp_valid0/1`=0, `busy`=0.
- Reset mid-operation discards the in-flight operation; no response is issued after release.
- Latency: accept at edge N; EXEC in cycle N+1; `rsp_valid` high in cycle N+2 (2 cycles accept-to-response).
- Minimum issue interval is 3 cycles: accept, EXEC, RESP with `rsp_ready` already high, then IDLE can accept on the next edge.
- If `rsp_ready` is held high before RESP, the response completes in its first RESP cycle.
- `rsp_data` is stable throughout RESP.
- Continuous contention alternates 0,1,0,1…. A single requester asserting back-to-back is served every time; `last` does not block it.
- `op_count` at 0xFFFF stays at 0xFFFF.
- `busy` = (state != IDLE), registered state decode.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-RESP → `rsp_valid0/1`=0, `aluin1`=`aluin2`=0, `funct3`=000, `op_count`=0 immediately. After release no stale response appears.
- **Single request:** port 0, a=7, b=10, funct3=000 (ADD) → `req_ready0`=1 same cycle; `aluin1`=7, `aluin2`=10 next cycle; `rsp_valid0`=1 with `rsp_data`=17 two cycles after accept; `op_count`=1.
- **Simultaneous requests:** both valid after reset (port 0: 7+10, port 1: 3+4) → port 0 served first (17), then port 1 (7). `rsp_valid1` never high during port 0's response.
- **Fairness:** both held valid for 6 operations → grant order 0,1,0,1,0,1. Each completes with issue spacing of 3 cycles when `rsp_ready` is tied high.
- **Response backpressure:** `rsp_ready0`=0 for 5 cycles in RESP → `rsp_valid0` and `rsp_data` held stable, `req_ready1`=0 throughout even with `req_valid1`=1. Port 1 is accepted the cycle after `rsp_ready0` rises.
- **Saturation:** force/preload 65534 completions → `op_count` reaches 0xFFFF and stays there after further operations.
